// File: rtl/display_pkg.sv
// Shared display constants and width helpers used by the mode selector
// and its button debouncer.
package display_pkg;

    localparam logic [7:0] SEG_BLANK_DATA = 8'h00;
    localparam logic [7:0] SEG_BLANK_COM  = 8'hFF;

    localparam int unsigned MODE_WATCH     = 0;
    localparam int unsigned MODE_STOPWATCH = 1;
    localparam int unsigned MODE_ALARM     = 2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

    // Bits needed to index n values, never less than one.
    function automatic int unsigned width_for(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: two-flop synchronizer, level debouncer and a
// one-cycle registered pulse on each accepted press.
module btn_debounce
    import display_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 3
) (
    input  logic clk_100hz,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned   CW       = width_for(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_prev_q, level_prev_d;
    logic          press_q, press_d;

    // Count consecutive synced samples that disagree with the accepted level.
    always_comb begin
        sync_d       = {sync_q[0], btn_raw};
        cnt_d        = '0;
        level_d      = level_q;
        level_prev_d = level_q;
        press_d      = level_q & ~level_prev_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/mode_display_mux.sv
// Display source selector: steps through enabled modes on a debounced
// button, returns home on inactivity, and drives the shared 7-seg bus.
module mode_display_mux
    import display_pkg::*;
#(
    parameter int unsigned NUM_MODES      = 3,
    parameter int unsigned SEG_W          = 8,
    parameter int unsigned HOME_MODE      = 0,
    parameter int unsigned DEBOUNCE_TICKS = 3,
    parameter int unsigned TIMEOUT_TICKS  = 3000
) (
    input  logic                            clk_100hz,
    input  logic                            rst,
    input  logic                            mode_btn,
    input  logic                            activity,
    input  logic [NUM_MODES-1:0]            mode_en,
    input  logic [NUM_MODES*SEG_W-1:0]      seg_data_in,
    input  logic [NUM_MODES*SEG_W-1:0]      seg_com_in,
    output logic [SEG_W-1:0]                seg_data,
    output logic [SEG_W-1:0]                seg_com,
    output logic [width_for(NUM_MODES)-1:0] mode_sel,
    output logic                            mode_changed
);

    localparam int unsigned      MW         = width_for(NUM_MODES);
    localparam int unsigned      IW         = width_for(TIMEOUT_TICKS + 1);
    localparam logic [MW-1:0]    HOME       = MW'(HOME_MODE);
    localparam logic [IW-1:0]    IDLE_LAST  = IW'((TIMEOUT_TICKS == 0) ? 0 : TIMEOUT_TICKS - 1);
    localparam logic [IW-1:0]    IDLE_MAX   = '1;
    localparam logic [SEG_W-1:0] BLANK_DATA = {SEG_W{SEG_BLANK_DATA[0]}};
    // Commons are active-low; blank drives every digit inactive.
    localparam logic [SEG_W-1:0] BLANK_COM  = {SEG_W{SEG_BLANK_COM[0]}};

    logic                 press;
    logic [NUM_MODES-1:0] en_eff_c;
    logic                 cur_en_c;
    logic                 nxt_found_c;
    logic [MW-1:0]        nxt_idx_c;
    logic                 idle_hit_c;

    logic [MW-1:0]    mode_sel_q, mode_sel_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic             mode_changed_q, mode_changed_d;
    logic [SEG_W-1:0] seg_data_q, seg_data_d;
    logic [SEG_W-1:0] seg_com_q, seg_com_d;

    btn_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_btn (
        .clk_100hz(clk_100hz),
        .rst      (rst),
        .btn_raw  (mode_btn),
        .press    (press)
    );

    assign en_eff_c = mode_en | (NUM_MODES'(1) << HOME_MODE);

    // Enable of the current mode and the nearest enabled mode ahead of it.
    always_comb begin
        int unsigned cur;
        int unsigned off;
        int unsigned best_off;
        cur         = 32'(mode_sel_q);
        off         = 0;
        best_off    = NUM_MODES;
        cur_en_c    = 1'b0;
        nxt_found_c = 1'b0;
        nxt_idx_c   = mode_sel_q;
        for (int unsigned k = 0; k < NUM_MODES; k++) begin
            off = (k >= cur) ? (k - cur) : (k + NUM_MODES - cur);
            if (mode_sel_q == MW'(k)) begin
                cur_en_c = en_eff_c[k];
            end
            if (en_eff_c[k] && (off != 0) && (off < best_off)) begin
                best_off    = off;
                nxt_idx_c   = MW'(k);
                nxt_found_c = 1'b1;
            end
        end
    end

    assign idle_hit_c = (TIMEOUT_TICKS != 0) && (mode_sel_q != HOME) && !press
                        && !activity && (idle_q == IDLE_LAST);

    // Mode selection: disabled-mode recovery beats a press, a press beats timeout.
    always_comb begin
        mode_sel_d = mode_sel_q;
        idle_d     = idle_q;
        if ((mode_sel_q != HOME) && !cur_en_c) begin
            mode_sel_d = HOME;
        end else if (press) begin
            if (nxt_found_c) begin
                mode_sel_d = nxt_idx_c;
            end
        end else if (idle_hit_c) begin
            mode_sel_d = HOME;
        end

        if (press || activity || (mode_sel_d != mode_sel_q) || (mode_sel_q == HOME)) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IW'(1);
        end

        mode_changed_d = (mode_sel_d != mode_sel_q);

        seg_data_d = BLANK_DATA;
        seg_com_d  = BLANK_COM;
        for (int unsigned k = 0; k < NUM_MODES; k++) begin
            if (mode_sel_q == MW'(k)) begin
                seg_data_d = seg_data_in[k*SEG_W +: SEG_W];
                seg_com_d  = seg_com_in[k*SEG_W +: SEG_W];
            end
        end
    end

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            mode_sel_q     <= HOME;
            idle_q         <= '0;
            mode_changed_q <= 1'b0;
            seg_data_q     <= BLANK_DATA;
            seg_com_q      <= BLANK_COM;
        end else begin
            mode_sel_q     <= mode_sel_d;
            idle_q         <= idle_d;
            mode_changed_q <= mode_changed_d;
            seg_data_q     <= seg_data_d;
            seg_com_q      <= seg_com_d;
        end
    end

    assign mode_sel     = mode_sel_q;
    assign mode_changed = mode_changed_q;
    assign seg_data     = seg_data_q;
    assign seg_com      = seg_com_q;

endmodule
